// File: rtl/dpram_sram_arb_if.sv
// dpram_sram_arb_if: port A/B req/ack buses plus the external SRAM pin bundle
interface dpram_sram_arb_if #(
  parameter int ADDR_WIDTH      = 15,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_ADDR_WIDTH = 19
);
  logic                       req_a, wren_a, ack_a;
  logic [ADDR_WIDTH-1:0]      address_a;
  logic [DATA_WIDTH-1:0]      data_a, q_a;
  logic                       req_b, wren_b, ack_b;
  logic [ADDR_WIDTH-1:0]      address_b;
  logic [DATA_WIDTH-1:0]      data_b, q_b;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0]      sram_dq_o, sram_dq_i;
  logic                       sram_dq_oe, sram_we_n, sram_oe_n, busy;
  modport slave (
    input  req_a, wren_a, address_a, data_a, req_b, wren_b, address_b, data_b, sram_dq_i,
    output ack_a, q_a, ack_b, q_b, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n, busy
  );
  modport master (
    output req_a, wren_a, address_a, data_a, req_b, wren_b, address_b, data_b, sram_dq_i,
    input  ack_a, q_a, ack_b, q_b, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n, busy
  );
endinterface

// File: rtl/dpram_sram_arb.sv
// dpram_sram_arb: two req/ack ports time-multiplexed onto one async SRAM; define DPSRAM_RR_ARB_EN for round-robin arbitration
module dpram_sram_arb #(
  parameter int          ADDR_WIDTH      = 15,
  parameter int          DATA_WIDTH      = 8,
  parameter int          SRAM_ADDR_WIDTH = 19,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int          WAIT_CYCLES     = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  dpram_sram_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       gnt_b_q, gnt_b_d, wr_q, wr_d, pick_b;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      dq_o_q, dq_o_d, q_a_q, q_a_d, q_b_q, q_b_d;
  logic                       dq_oe_q, dq_oe_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic                       ack_a_q, ack_a_d, ack_b_q, ack_b_d, busy_q;
`ifdef DPSRAM_RR_ARB_EN
  // gnt_b_q doubles as grant history: on a tie the port not served last wins
  assign pick_b = bus.req_b && (!bus.req_a || !gnt_b_q);
`else
  assign pick_b = bus.req_b && !bus.req_a;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_b_d = gnt_b_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = dq_oe_q;
    we_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    q_a_d   = q_a_q;
    q_b_d   = q_b_q;
    unique case (state_q)
      IDLE: if (bus.req_a || bus.req_b) begin
        state_d = SETUP;
        gnt_b_d = pick_b;
        wr_d    = pick_b ? bus.wren_b : bus.wren_a;
        addr_d  = SRAM_ADDR_WIDTH'(BASE_ADDR) + SRAM_ADDR_WIDTH'(pick_b ? bus.address_b : bus.address_a);
        dq_o_d  = pick_b ? bus.data_b : bus.data_a;
        dq_oe_d = wr_d;
        oe_n_d  = wr_d;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYCLES);
        we_n_d  = !wr_q;
        oe_n_d  = wr_q;
      end
      ACCESS: if (cnt_q == 4'd0) begin
        // read data is captured on the edge that ends the last access cycle
        state_d = DONE;
        ack_a_d = !gnt_b_q;
        ack_b_d = gnt_b_q;
        q_a_d   = (!wr_q && !gnt_b_q) ? bus.sram_dq_i : q_a_q;
        q_b_d   = (!wr_q && gnt_b_q) ? bus.sram_dq_i : q_b_q;
      end else begin
        cnt_d  = cnt_q - 4'd1;
        we_n_d = !wr_q;
        oe_n_d = wr_q;
      end
      DONE: begin
        state_d = IDLE;
        dq_oe_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_b_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      q_a_q   <= '0;
      q_b_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_b_q <= gnt_b_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      q_a_q   <= q_a_d;
      q_b_q   <= q_b_d;
      busy_q  <= state_d != IDLE;
    end
  end
  assign bus.sram_addr  = addr_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.ack_a      = ack_a_q;
  assign bus.ack_b      = ack_b_q;
  assign bus.q_a        = q_a_q;
  assign bus.q_b        = q_b_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dpram_sram_arb.sv
// tb_dpram_sram_arb: scoreboard bench; dut0 BASE=0/WAIT=1, dut1 BASE=0x40000/WAIT=0
module tb_dpram_sram_arb;
`ifdef DPSRAM_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {bit b; bit rd; logic [7:0] q;} exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  exp_t e;
  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  dpram_sram_arb_if bus0();
  dpram_sram_arb_if bus1();
  dpram_sram_arb #(.BASE_ADDR(0), .WAIT_CYCLES(1)) dut0 (.clock(clk), .reset_n(reset_n), .bus(bus0));
  dpram_sram_arb #(.BASE_ADDR(32'h40000), .WAIT_CYCLES(0)) dut1 (.clock(clk), .reset_n(reset_n), .bus(bus1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= 8'h00;
        mem1[i] <= 8'h00;
      end
    end else begin
      if (!bus0.sram_we_n) mem0[bus0.sram_addr[11:0]] <= bus0.sram_dq_o;
      if (!bus1.sram_we_n) mem1[bus1.sram_addr[11:0]] <= bus1.sram_dq_o;
    end
  end
  assign bus0.sram_dq_i = mem0[bus0.sram_addr[11:0]];
  assign bus1.sram_dq_i = mem1[bus1.sram_addr[11:0]];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  // monitor: every ack on dut0 must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus0.ack_a || bus0.ack_b) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'({bus0.ack_b, bus0.ack_a}), 0);
      else begin
        e = sb.pop_front();
        chk("ack_port", 32'({bus0.ack_b, bus0.ack_a}), e.b ? 2 : 1);
        if (e.rd) chk(e.b ? "rdata_b" : "rdata_a", 32'(e.b ? bus0.q_b : bus0.q_a), 32'(e.q));
      end
    end
  end
  task automatic drive(input bit b, r, wr, input logic [14:0] a, input logic [7:0] d);
    if (b) begin
      bus0.req_b = r; bus0.wren_b = wr; bus0.address_b = a; bus0.data_b = d;
    end else begin
      bus0.req_a = r; bus0.wren_a = wr; bus0.address_a = a; bus0.data_a = d;
    end
  endtask
  task automatic xfer(virtual dpram_sram_arb_if vif, input bit track, b, wr, input logic [14:0] a,
                      input logic [7:0] d, output int lat, we_lo, dqoe_hi, oen_lo, busy_hi,
                      output logic [18:0] sa);
    int t0;
    lat = -1; we_lo = 0; dqoe_hi = 0; oen_lo = 0; busy_hi = 0; sa = '0;
    @(posedge clk); #1;
    if (track) sb.push_back('{b, !wr, d});
    if (b) begin
      vif.req_b = 1'b1; vif.wren_b = wr; vif.address_b = a; vif.data_b = d;
    end else begin
      vif.req_a = 1'b1; vif.wren_a = wr; vif.address_a = a; vif.data_a = d;
    end
    t0 = cyc;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (!vif.sram_we_n) we_lo++;
      if (vif.sram_dq_oe) dqoe_hi++;
      if (!vif.sram_oe_n) oen_lo++;
      if (vif.busy && busy_hi == 0) sa = vif.sram_addr;
      if (vif.busy) busy_hi++;
      if (b ? vif.ack_b : vif.ack_a) lat = cyc - t0;
    end
    chk("xfer_ack_seen", 32'(lat >= 0), 1);
    @(posedge clk); #1;
    if (b) vif.req_b = 1'b0; else vif.req_a = 1'b0;
  endtask
  // holds req high across n back-to-back transactions, stepping address/data after each ack
  task automatic stream(input bit b, input int n, input bit wr, input logic [14:0] a0, input logic [7:0] d0);
    bit seen;
    @(posedge clk); #1;
    drive(b, 1'b1, wr, a0, d0);
    for (int k = 0; k < n; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        seen = b ? bus0.ack_b : bus0.ack_a;
      end
      if (!seen) begin
        chk("stream_ack_seen", 32'(seen), 1);
        break;
      end
      @(posedge clk); #1;
      drive(b, k < n - 1, wr, a0 + 15'(k + 1), d0 + 8'(k + 1));
    end
    drive(b, 1'b0, wr, a0, d0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int lat, we_lo, dqoe_hi, oen_lo, busy_hi;
    logic [18:0] sa;
    bit seen;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    bus1.req_a = 1'b0; bus1.wren_a = 1'b0; bus1.address_a = '0; bus1.data_a = '0;
    bus1.req_b = 1'b0; bus1.wren_b = 1'b0; bus1.address_b = '0; bus1.data_b = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_we_n", 32'(bus0.sram_we_n), 1);
    chk("rst_oe_n", 32'(bus0.sram_oe_n), 1);
    chk("rst_dq_oe", 32'(bus0.sram_dq_oe), 0);
    chk("rst_addr", 32'(bus0.sram_addr), 0);
    chk("rst_dq_o", 32'(bus0.sram_dq_o), 0);
    chk("rst_acks", 32'({bus0.ack_a, bus0.ack_b}), 0);
    chk("rst_qs", 32'({bus0.q_a, bus0.q_b}), 0);
    chk("rst_busy", 32'(bus0.busy), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    // single write then read-back on port A
    xfer(bus0, 1'b1, 1'b0, 1'b1, 15'h0123, 8'h5A, lat, we_lo, dqoe_hi, oen_lo, busy_hi, sa);
    chk("wr_latency", 32'(lat), 4);
    chk("wr_we_n_low", 32'(we_lo), 2);
    chk("wr_dq_oe_high", 32'(dqoe_hi), 4);
    chk("wr_busy_high", 32'(busy_hi), 4);
    chk("wr_sram_addr", 32'(sa), 32'h00123);
    chk("wr_q_a_unchanged", 32'(bus0.q_a), 0);
    xfer(bus0, 1'b1, 1'b0, 1'b0, 15'h0123, 8'h5A, lat, we_lo, dqoe_hi, oen_lo, busy_hi, sa);
    chk("rd_latency", 32'(lat), 4);
    chk("rd_oe_n_low", 32'(oen_lo), 3);
    chk("rd_we_n_low", 32'(we_lo), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_q_a_held", 32'(bus0.q_a), 32'h5A);
    chk("rd_q_b_zero", 32'(bus0.q_b), 0);
    chk("idle_busy", 32'(bus0.busy), 0);
    // simultaneous A write / B read of the same address
    if (RR) begin
      sb.push_back('{1'b1, 1'b1, 8'h00});
      sb.push_back('{1'b0, 1'b0, 8'h11});
    end else begin
      sb.push_back('{1'b0, 1'b0, 8'h11});
      sb.push_back('{1'b1, 1'b1, 8'h11});
    end
    fork
      stream(1'b0, 1, 1'b1, 15'h0010, 8'h11);
      stream(1'b1, 1, 1'b0, 15'h0010, 8'h00);
    join
    // A streams 3 writes while B streams 2 reads
    if (RR) begin
      sb.push_back('{1'b1, 1'b1, 8'h00});
      sb.push_back('{1'b0, 1'b0, 8'hA0});
      sb.push_back('{1'b1, 1'b1, 8'h00});
      sb.push_back('{1'b0, 1'b0, 8'hA1});
      sb.push_back('{1'b0, 1'b0, 8'hA2});
    end else begin
      sb.push_back('{1'b0, 1'b0, 8'hA0});
      sb.push_back('{1'b0, 1'b0, 8'hA1});
      sb.push_back('{1'b0, 1'b0, 8'hA2});
      sb.push_back('{1'b1, 1'b1, 8'h00});
      sb.push_back('{1'b1, 1'b1, 8'h00});
    end
    fork
      stream(1'b0, 3, 1'b1, 15'h0020, 8'hA0);
      stream(1'b1, 2, 1'b0, 15'h0030, 8'h00);
    join
    xfer(bus0, 1'b1, 1'b1, 1'b0, 15'h0021, 8'hA1, lat, we_lo, dqoe_hi, oen_lo, busy_hi, sa);
    // base offset and zero wait states on dut1
    xfer(bus1, 1'b0, 1'b0, 1'b1, 15'h7FFF, 8'h3C, lat, we_lo, dqoe_hi, oen_lo, busy_hi, sa);
    chk("w0_latency", 32'(lat), 3);
    chk("w0_we_n_low", 32'(we_lo), 1);
    chk("w0_sram_addr", 32'(sa), 32'h47FFF);
    xfer(bus1, 1'b0, 1'b0, 1'b0, 15'h7FFF, 8'h3C, lat, we_lo, dqoe_hi, oen_lo, busy_hi, sa);
    chk("w0_rd_q_a", 32'(bus1.q_a), 32'h3C);
    chk("w0_rd_oe_n_low", 32'(oen_lo), 2);
    // reset pulse in the middle of a write access
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 15'h0040, 8'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_we_n_active", 32'(bus0.sram_we_n), 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we_n", 32'(bus0.sram_we_n), 1);
    chk("mid_rst_dq_oe", 32'(bus0.sram_dq_oe), 0);
    chk("mid_rst_busy", 32'(bus0.busy), 0);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus0.ack_a | bus0.ack_b;
    end
    chk("mid_rst_no_ack", 32'(seen), 0);
    xfer(bus0, 1'b1, 1'b0, 1'b1, 15'h0041, 8'h99, lat, we_lo, dqoe_hi, oen_lo, busy_hi, sa);
    chk("post_rst_latency", 32'(lat), 4);
    xfer(bus0, 1'b1, 1'b0, 1'b0, 15'h0041, 8'h99, lat, we_lo, dqoe_hi, oen_lo, busy_hi, sa);
    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
